// File: rtl/ndp_egress_queue_if.sv
// rtl/ndp_egress_queue_if.sv - crossbar-side write, consumer-side handshake and status bundle for one egress queue
//
// Signals:
//   in_wr/in_ctl/in_data           write strobe and word from the crossbar output (no backpressure)
//   out_valid/out_ready            head-entry handshake towards the port MAC
//   out_ctl/out_data               show-ahead head word, zero while out_valid is low
//   count/nearly_full/drop_cnt     occupancy and drop status
// Modports: master = crossbar + consumer side, slave = the queue.
interface ndp_egress_queue_if #(
    parameter int DATA_WIDTH = 480,
    parameter int CTRL_WIDTH = 32,
    parameter int DEPTH_BITS = 3,
    parameter int DROP_W     = 16
);
    logic                  in_wr;
    logic [CTRL_WIDTH-1:0] in_ctl;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [CTRL_WIDTH-1:0] out_ctl;
    logic [DATA_WIDTH-1:0] out_data;
    logic [DEPTH_BITS:0]   count;
    logic                  nearly_full;
    logic [DROP_W-1:0]     drop_cnt;

    modport master (
        output in_wr, in_ctl, in_data, out_ready,
        input  out_valid, out_ctl, out_data, count, nearly_full, drop_cnt
    );

    modport slave (
        input  in_wr, in_ctl, in_data, out_ready,
        output out_valid, out_ctl, out_data, count, nearly_full, drop_cnt
    );
endinterface

// File: rtl/ndp_egress_queue.sv
// rtl/ndp_egress_queue.sv - per-port egress buffer absorbing crossbar bursts, draining over valid/ready
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   q     ndp_egress_queue_if.slave: crossbar write side, consumer handshake, occupancy/drop status
module ndp_egress_queue #(
    parameter int DATA_WIDTH = 480,
    parameter int CTRL_WIDTH = 32,
    parameter int DEPTH_BITS = 3,
    parameter int NF_SLACK   = 1,
    parameter int DROP_W     = 16
) (
    input logic               clk,
    input logic               rst,
    ndp_egress_queue_if.slave q
);
    localparam int WORD_W = CTRL_WIDTH + DATA_WIDTH;
    localparam int DEPTH  = 2 ** DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_C = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] NF_THR  = (DEPTH_BITS + 1)'(DEPTH - NF_SLACK);

    // ctl and data live together so a head read is a single array access
    logic [WORD_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;

    logic              valid;
    logic              pop;
    logic              push;
    logic              drop;
    logic [WORD_W-1:0] head;

    assign valid = (count_q != '0);
    assign pop   = valid & q.out_ready;
    // a full buffer still accepts when the head leaves on the same edge
    assign push  = q.in_wr & ((count_q < DEPTH_C) | pop);
    assign drop  = q.in_wr & ~push;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // storage is never cleared; pointers reset so stale entries are unreachable
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_q[wr_ptr_q] <= {q.in_ctl, q.in_data};
        end
    end

    assign q.out_valid   = valid;
    assign q.out_ctl     = valid ? head[WORD_W-1:DATA_WIDTH] : '0;
    assign q.out_data    = valid ? head[DATA_WIDTH-1:0]      : '0;
    assign q.count       = count_q;
    assign q.nearly_full = (count_q >= NF_THR);
    assign q.drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_ndp_egress_queue.sv
// tb/tb_ndp_egress_queue.sv - scoreboard bench for ndp_egress_queue
module tb_ndp_egress_queue;
    localparam int DW  = 480;
    localparam int CW  = 32;
    localparam int DB  = 3;
    localparam int DRW = 4;
    localparam int DEP = 8;

    logic clk;
    logic rst;

    ndp_egress_queue_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .DEPTH_BITS(DB), .DROP_W(DRW)) bus ();

    ndp_egress_queue #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .DEPTH_BITS(DB), .NF_SLACK(1), .DROP_W(DRW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [511:0] sb [$];
    int unsigned  m_drop;
    int           n_chk;
    int           n_pass;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    // Called at a negedge: check the current outputs against the model, then
    // drive the next cycle's inputs and advance the model across the edge.
    task automatic cycle(input logic wr, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ready);
        bit pop;
        bit push;
        logic [511:0] item;
        chk("count", 512'(bus.count), 512'(sb.size()));
        chk("out_valid", 512'(bus.out_valid), 512'(sb.size() != 0));
        chk("nearly_full", 512'(bus.nearly_full), 512'(sb.size() >= DEP - 1));
        chk("drop_cnt", 512'(bus.drop_cnt), 512'(m_drop));
        if (sb.size() == 0) begin
            chk("idle_zero", {bus.out_ctl, bus.out_data}, '0);
        end
        bus.in_wr     = wr;
        bus.in_ctl    = c;
        bus.in_data   = d;
        bus.out_ready = ready;
        pop  = (sb.size() != 0) && ready;
        push = wr && ((sb.size() < DEP) || pop);
        if (pop) begin
            item = sb.pop_front();
            chk("head", {bus.out_ctl, bus.out_data}, item);
        end
        if (push) begin
            sb.push_back({c, d});
        end
        if (wr && !push && m_drop != 15) begin
            m_drop++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst           = 1'b0;
        bus.in_wr     = 1'b1;
        bus.in_ctl    = $urandom;
        bus.in_data   = rand_data();
        bus.out_ready = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        bus.in_wr = 1'b0;
        sb.delete();
        m_drop = 0;
    endtask

    task automatic idle(input int n, input logic ready);
        repeat (n) cycle(1'b0, '0, '0, ready);
    endtask

    initial begin
        n_chk         = 0;
        n_pass        = 0;
        m_drop        = 0;
        rst           = 1'b0;
        bus.in_wr     = 1'b0;
        bus.in_ctl    = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);

        // reset held two cycles with writes asserted
        do_reset(2);
        idle(1, 1'b0);

        // single word, then release
        cycle(1'b1, 32'h5, 480'hA5, 1'b0);
        chk("single_ctl", 512'(bus.out_ctl), 512'h5);
        chk("single_data", 512'(bus.out_data), 512'hA5);
        idle(1, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b0);

        // fill past full, drain in order
        do_reset(1);
        repeat (10) cycle(1'b1, $urandom, rand_data(), 1'b0);
        chk("fill_drops", 512'(bus.drop_cnt), 512'd2);
        idle(8, 1'b1);
        idle(1, 1'b0);

        // full with simultaneous write and pop
        repeat (8) cycle(1'b1, $urandom, rand_data(), 1'b0);
        cycle(1'b1, $urandom, rand_data(), 1'b1);
        idle(8, 1'b1);
        idle(1, 1'b0);

        // pointer wrap: 20 words, ready toggling
        do_reset(1);
        for (int i = 0; i < 40; i++) begin
            cycle(i % 2 == 0, $urandom, rand_data(), (i % 2 == 0));
        end
        idle(12, 1'b1);
        chk("wrap_drops", 512'(bus.drop_cnt), '0);

        // saturation, then reset mid-stream
        do_reset(1);
        repeat (28) cycle(1'b1, $urandom, rand_data(), 1'b0);
        chk("sat_drops", 512'(bus.drop_cnt), 512'hF);
        repeat (3) cycle(1'b1, $urandom, rand_data(), 1'b0);
        do_reset(1);
        idle(1, 1'b0);
        chk("rst_drops", 512'(bus.drop_cnt), '0);
        repeat (3) cycle(1'b1, $urandom, rand_data(), 1'b0);
        idle(4, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
